slon5_test: RTL and testbench

Pipelined 32-bit substitution–permutation mixing core used as the slon5 bring-up block. Every clock it accepts a 16-bit input number `sw`, expands it to a 32-bit word and pushes it through `STAGE_NUM` registered rounds. Each round adds a round constant (KTable), applies a 4-bit S-box to every nibble (STable) and does a rotate-xor diffusion step. The result leaves on `dout`, tagged with the input number that produced it on `dnum`. The constant tables live in `slon5_pkg` so the bench can verify and print them.

---
 rtl/slon5_test.sv | 152 +++++++++++++++
 tb/tb_slon5_test.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/slon5_test.sv
// slon5 bring-up mixing core: a pipelined 32-bit substitution-permutation network.
// Each input tag is expanded to a 32-bit word and run through STAGE_NUM registered rounds.
// The result word leaves on dout, alongside the tag that produced it on dnum.

package slon5_pkg;

   localparam int WORD_WIDTH = 32;
   localparam int STAGE_NUM  = 8;
   localparam int DNUM_WIDTH = 16;

   typedef logic [DNUM_WIDTH-1:0] Dnum_t;
   typedef logic [WORD_WIDTH-1:0] Dout_t;

   // Round constants: multiples of the golden-ratio constant, mod 2^32.
   localparam logic [31:0] KTable [0:STAGE_NUM-1] = '{
      32'h9E3779B9, 32'h3C6EF372, 32'hDAA66D2B, 32'h78DDE6E4,
      32'h1715609D, 32'hB54CDA56, 32'h5384540F, 32'hF1BBCDC8
   };

   // 4-bit S-box applied to every nibble.
   localparam logic [3:0] STable [0:15] = '{
      4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
      4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
   };

   // Round constant for any round index, so pipelines deeper than the table still work.
   function automatic logic [31:0] k_const(input int unsigned idx);
      logic [31:0] mult;
      mult = 32'(idx + 32'd1);
      return 32'h9E3779B9 * mult;
   endfunction

   // Nibble-wise substitution, each nibble replaced in place.
   function automatic logic [31:0] sbox32(input logic [31:0] t);
      logic [31:0] u;
      u = 32'h0000_0000;
      for (int j = 0; j < 8; j++) begin
         u[4*j +: 4] = STable[t[4*j +: 4]];
      end
      return u;
   endfunction

   // One full round: constant add (carry dropped), substitution, rotate-xor diffusion.
   function automatic logic [31:0] round_f(input logic [31:0] x, input logic [31:0] k);
      logic [31:0] t;
      logic [31:0] u;
      t = x + k;
      u = sbox32(t);
      return u ^ {u[26:0], u[31:27]};
   endfunction

endpackage

module slon5_test
   import slon5_pkg::*;
#(
   parameter int WORD_WIDTH = 32,
   parameter int STAGE_NUM  = 8,
   parameter int DNUM_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DNUM_WIDTH-1:0] sw,
   output logic [WORD_WIDTH-1:0] dout,
   output logic [DNUM_WIDTH-1:0] dnum
);

   // Input capture: raw tag plus its valid bit.
   logic [DNUM_WIDTH-1:0] in_q;
   logic                  in_vld_q;

   // Stage 0: expanded word, tag and valid.
   logic [WORD_WIDTH-1:0] x0_q;
   logic [DNUM_WIDTH-1:0] n0_q;
   logic                  v0_q;

   // Round stages.
   logic [WORD_WIDTH-1:0] x_q [0:STAGE_NUM-1];
   logic [DNUM_WIDTH-1:0] n_q [0:STAGE_NUM-1];
   logic                  v_q [0:STAGE_NUM-1];
   logic [WORD_WIDTH-1:0] rnd_d [0:STAGE_NUM-1];

   // Output register.
   logic [WORD_WIDTH-1:0] dout_q;
   logic [DNUM_WIDTH-1:0] dnum_q;

   // Combinational round logic feeding each round register.
   always_comb begin
      for (int i = 0; i < STAGE_NUM; i++) begin
         rnd_d[i] = {WORD_WIDTH{1'b0}};
      end
      rnd_d[0] = round_f(x0_q, k_const(32'd0));
      for (int i = 1; i < STAGE_NUM; i++) begin
         rnd_d[i] = round_f(x_q[i-1], k_const(32'(i)));
      end
   end

   // Input capture and expansion registers; reset discards anything in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         in_q     <= {DNUM_WIDTH{1'b0}};
         in_vld_q <= 1'b0;
         x0_q     <= {WORD_WIDTH{1'b0}};
         n0_q     <= {DNUM_WIDTH{1'b0}};
         v0_q     <= 1'b0;
      end else begin
         in_q     <= sw;
         in_vld_q <= 1'b1;
         x0_q     <= {~in_q, in_q};
         n0_q     <= in_q;
         v0_q     <= in_vld_q;
      end
   end

   // Round registers: word advances through a round, tag and valid ride along unchanged.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < STAGE_NUM; i++) begin
            x_q[i] <= {WORD_WIDTH{1'b0}};
            n_q[i] <= {DNUM_WIDTH{1'b0}};
            v_q[i] <= 1'b0;
         end
      end else begin
         x_q[0] <= rnd_d[0];
         n_q[0] <= n0_q;
         v_q[0] <= v0_q;
         for (int i = 1; i < STAGE_NUM; i++) begin
            x_q[i] <= rnd_d[i];
            n_q[i] <= n_q[i-1];
            v_q[i] <= v_q[i-1];
         end
      end
   end

   // Output register: load on a valid final-stage word, otherwise hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         dout_q <= {WORD_WIDTH{1'b0}};
         dnum_q <= {DNUM_WIDTH{1'b0}};
      end else if (v_q[STAGE_NUM-1]) begin
         dout_q <= x_q[STAGE_NUM-1];
         dnum_q <= n_q[STAGE_NUM-1];
      end else begin
         dout_q <= dout_q;
         dnum_q <= dnum_q;
      end
   end

   assign dout = dout_q;
   assign dnum = dnum_q;

endmodule

// File: tb/tb_slon5_test.sv
// Testbench for slon5_test: default 8-round core and a 1-round core run side by side,
// each checked every cycle against a queue-based scoreboard fed by an independent model.

module tb_slon5_test;
   import slon5_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] sw;
   logic [31:0] dout_a;
   logic [15:0] dnum_a;
   logic [31:0] dout_b;
   logic [15:0] dnum_b;

   int tests = 0;
   int fails = 0;

   localparam int LAT_A = 10;
   localparam int LAT_B = 3;

   typedef struct packed {
      logic [15:0] num;
      logic [31:0] word;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];
   exp_t cur_a;
   exp_t cur_b;

   localparam logic [3:0] REF_S [0:15] = '{
      4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
      4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
   };

   always #5 clk = ~clk;

   slon5_test u_dut_a (
      .clk  (clk),
      .rst  (rst),
      .sw   (sw),
      .dout (dout_a),
      .dnum (dnum_a)
   );

   slon5_test #(.STAGE_NUM(1)) u_dut_b (
      .clk  (clk),
      .rst  (rst),
      .sw   (sw),
      .dout (dout_b),
      .dnum (dnum_b)
   );

   function automatic logic [31:0] model(input logic [15:0] s, input int stages);
      logic [31:0] x;
      logic [31:0] t;
      logic [31:0] u;
      logic [31:0] k;
      x = {~s, s};
      for (int r = 0; r < stages; r++) begin
         k = 32'h9E3779B9 * 32'(r + 1);
         t = x + k;
         for (int j = 0; j < 8; j++) begin
            u[4*j +: 4] = REF_S[t[4*j +: 4]];
         end
         x = u ^ ((u << 5) | (u >> 27));
      end
      return x;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      tests++;
      assert (obs === exp_v) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   // One clock: update scoreboards with what was sampled, then compare both cores.
   task automatic step();
      exp_t e;
      @(posedge clk);
      if (rst) begin
         q_a.delete();
         q_b.delete();
         cur_a = '0;
         cur_b = '0;
      end else begin
         e.num  = sw;
         e.word = model(sw, 8);
         q_a.push_back(e);
         e.word = model(sw, 1);
         q_b.push_back(e);
         if (q_a.size() == LAT_A + 1) cur_a = q_a.pop_front();
         if (q_b.size() == LAT_B + 1) cur_b = q_b.pop_front();
      end
      #1;
      check("dout8", dout_a, cur_a.word);
      check("dnum8", {16'h0000, dnum_a}, {16'h0000, cur_a.num});
      check("dout1", dout_b, cur_b.word);
      check("dnum1", {16'h0000, dnum_b}, {16'h0000, cur_b.num});
   endtask

   initial begin
      logic [31:0] ref_k;
      logic [15:0] seen;
      rst   = 1'b1;
      sw    = 16'h0000;
      cur_a = '0;
      cur_b = '0;

      // Constant tables.
      $display("[TB] clog2(WORD_WIDTH)=%0d clog2(STAGE_NUM)=%0d", $clog2(WORD_WIDTH), $clog2(STAGE_NUM));
      for (int i = 0; i < 8; i++) begin
         ref_k = 32'h9E3779B9 * 32'(i + 1);
         $display("[TB] KTable[%0d]=%h", i, KTable[i]);
         check("ktable", KTable[i], ref_k);
      end
      seen = 16'h0000;
      for (int i = 0; i < 16; i++) begin
         $display("[TB] STable[%0d]=%h", i, STable[i]);
         check("stable", {28'h0, STable[i]}, {28'h0, REF_S[i]});
         seen[STable[i]] = 1'b1;
      end
      check("stable_perm", {16'h0000, seen}, 32'h0000FFFF);

      // Reset for one clock, then fill with a counter starting at 0.
      step();
      rst = 1'b0;
      sw  = 16'h0000;
      for (int c = 0; c < 100; c++) begin
         step();
         sw = sw + 16'd1;
         // Mid-stream reset pulse.
         rst = (c == 39) ? 1'b1 : 1'b0;
      end

      // Wrap through 0xFFFF -> 0x0000.
      sw = 16'hFFFE;
      for (int c = 0; c < 20; c++) begin
         step();
         sw = sw + 16'd1;
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
